// File: rtl/md_sequencer_pkg.sv
// ============================================================================
// Module      : md_sequencer_pkg
// Description : Shared MD operation codes, FSM states and default latencies
//               for the E-stage multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_sequencer_pkg;

  // MD operation codes shared with the decoder and the hazard unit
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  // Sequencer states
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  // Default latencies of the modelled multiplier and divider
  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_CNT_W    = 4;

endpackage

`default_nettype wire

// File: rtl/md_sequencer_arith.sv
// ============================================================================
// Module      : md_arith
// Description : Combinational multiply/divide datapath. Produces HI/LO results
//               for mult/multu/div/divu and flags a zero divisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  md_op_t      w_op;
  logic        w_signed_div;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_op = md_op_t'(op);

  // Both products are formed at full 64-bit width from extended operands
  assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_uprod = {32'd0, a} * {32'd0, b};

  // Signed division works on magnitudes; the divisor is forced to 1 when
  // zero so the divider never sees a zero operand (result is discarded).
  assign w_signed_div = (w_op == MD_DIV);
  assign w_dividend   = (w_signed_div && a[31]) ? (32'd0 - a) : a;
  assign w_divisor    = (b == 32'd0) ? 32'd1 :
                        ((w_signed_div && b[31]) ? (32'd0 - b) : b);
  assign w_quot       = w_dividend / w_divisor;
  assign w_rem        = w_dividend % w_divisor;

  // Select the result for the requested operation and restore signs
  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (w_op)
      MD_MULT:  {res_hi, res_lo} = w_sprod;
      MD_MULTU: {res_hi, res_lo} = w_uprod;
      MD_DIV: begin
        res_lo   = (a[31] ^ b[31]) ? (32'd0 - w_quot) : w_quot;
        res_hi   = a[31] ? (32'd0 - w_rem) : w_rem;
        div_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        res_lo   = w_quot;
        res_hi   = w_rem;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module      : md_sequencer
// Description : E-stage multiply/divide sequencer owning HI/LO. Models fixed
//               latency mult/div, drives start/busy for the stall unit and
//               serves mfhi/mflo/mthi/mtlo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] rs_val_E,
  input  logic [31:0] rt_val_E,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data_E
);

  localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  md_op_t      w_op;
  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;
  logic        w_idle;
  logic        w_is_arith;
  logic        w_is_div;
  logic        w_last;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div_zero;

  assign w_op       = md_op_t'(md_op_E);
  assign w_idle     = (r_state == S_IDLE);
  assign w_is_div   = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_is_arith = (w_op == MD_MULT) || (w_op == MD_MULTU) || w_is_div;
  assign w_last     = (r_state == S_RUN) && (r_cnt == c_CNT_ONE);

  assign start = w_is_arith && w_idle;
  assign busy  = (r_state == S_RUN);
  assign hi    = r_hi;
  assign lo    = r_lo;

  md_arith u_arith (
    .op       (md_op_E),
    .a        (rs_val_E),
    .b        (rt_val_E),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave IDLE on start, return when the counter expires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter, captured results and HI/LO; a zero divisor suppresses commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else if (start) begin
      r_cnt     <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_we <= !w_div_zero;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - c_CNT_ONE;
      if (w_last && r_pend_we) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_op == MD_MTHI) begin
      r_hi <= rs_val_E;
    end else if (w_op == MD_MTLO) begin
      r_lo <= rs_val_E;
    end
  end

  // HI/LO read path for mfhi/mflo; suppressed while an operation runs
  always_comb begin
    mf_data_E = 32'd0;
    if (w_idle) begin
      if (w_op == MD_MFHI)      mf_data_E = r_hi;
      else if (w_op == MD_MFLO) mf_data_E = r_lo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
// Module      : tb_md_sequencer
// Description : Self-checking bench for md_sequencer: behavioural HI/LO model
//               compared every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int L_MULT = 5;
  localparam int L_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op_E = 4'd0;
  logic [31:0] rs_val_E = 32'd0;
  logic [31:0] rt_val_E = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data_E;

  int n_checks = 0;
  int n_fail   = 0;
  int n_illegal = 0;

  // Behavioural model state
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_res_hi = 32'd0;
  logic [31:0] m_res_lo = 32'd0;
  logic        m_res_ok = 1'b0;

  md_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .md_op_E   (md_op_E),
    .rs_val_E  (rs_val_E),
    .rt_val_E  (rt_val_E),
    .start     (start),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .mf_data_E (mf_data_E)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Model: an operation is a countdown of busy cycles carrying a result
  always @(posedge clk or negedge reset) begin
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    if (!reset) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_res_hi = 0; m_res_lo = 0; m_res_ok = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_res_ok) begin
        m_hi = m_res_hi;
        m_lo = m_res_lo;
      end
    end else if (is_arith(md_op_E)) begin
      sa = longint'(int'(rs_val_E));
      sb = longint'(int'(rt_val_E));
      ua = {32'd0, rs_val_E};
      ub = {32'd0, rt_val_E};
      m_res_ok = 1'b1;
      case (md_op_E)
        MD_MULT: begin sq = sa * sb; {m_res_hi, m_res_lo} = sq; m_left = L_MULT; end
        MD_MULTU: begin up = ua * ub; {m_res_hi, m_res_lo} = up; m_left = L_MULT; end
        MD_DIV: begin
          m_left = L_DIV;
          if (sb == 0) m_res_ok = 1'b0;
          else begin sq = sa / sb; sr = sa % sb; m_res_lo = sq[31:0]; m_res_hi = sr[31:0]; end
        end
        default: begin
          m_left = L_DIV;
          if (ub == 0) m_res_ok = 1'b0;
          else begin up = ua / ub; m_res_lo = up[31:0]; up = ua % ub; m_res_hi = up[31:0]; end
        end
      endcase
    end else if (md_op_E == MD_MTHI) begin
      m_hi = rs_val_E;
    end else if (md_op_E == MD_MTLO) begin
      m_lo = rs_val_E;
    end
  end

  // Per-cycle comparison against the model, plus illegal-op monitor
  always @(negedge clk) begin
    logic [31:0] exp_mf;
    exp_mf = 32'd0;
    if (m_left == 0 && md_op_E == MD_MFHI) exp_mf = m_hi;
    if (m_left == 0 && md_op_E == MD_MFLO) exp_mf = m_lo;
    check("start", {31'd0, start}, {31'd0, is_arith(md_op_E) && m_left == 0});
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("mf_data_E", mf_data_E, exp_mf);
    if (reset && busy && md_op_E != MD_NONE) n_illegal++;
  end

  // Drive one cycle's inputs just after the edge, return mid-cycle
  task automatic cyc(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    md_op_E  = op;
    rs_val_E = rs;
    rt_val_E = rt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(MD_NONE, 32'd0, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: mult -2 * 3
    cyc(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("t1_start", {31'd0, start}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc(MD_NONE, 32'd0, 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd1);
    end
    cyc(MD_NONE, 32'd0, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFFA);

    // 2: divu 100/7 then mflo in first idle cycle
    cyc(MD_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      cyc(MD_NONE, 32'd0, 32'd0);
      check("t2_busy", {31'd0, busy}, 32'd1);
    end
    cyc(MD_MFLO, 32'd0, 32'd0);
    check("t2_mf", mf_data_E, 32'd14);
    check("t2_hi", hi, 32'd2);

    // 3: div -7/2 then the overflow case back to back
    cyc(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    cyc(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("t3a_lo", lo, 32'hFFFF_FFFD);
    check("t3a_hi", hi, 32'hFFFF_FFFF);
    check("t3b_start", {31'd0, start}, 32'd1);
    idle(10);
    cyc(MD_NONE, 32'd0, 32'd0);
    check("t3b_lo", lo, 32'h8000_0000);
    check("t3b_hi", hi, 32'd0);

    // 4: mthi then divide by zero
    cyc(MD_MTHI, 32'h0000_1234, 32'd0);
    cyc(MD_DIV, 32'd5, 32'd0);
    check("t4_mthi", hi, 32'h0000_1234);
    for (int i = 0; i < 10; i++) begin
      cyc(MD_NONE, 32'd0, 32'd0);
      check("t4_busy", {31'd0, busy}, 32'd1);
    end
    cyc(MD_NONE, 32'd0, 32'd0);
    check("t4_busy_end", {31'd0, busy}, 32'd0);
    check("t4_hi", hi, 32'h0000_1234);
    check("t4_lo", lo, 32'h8000_0000);

    // 5: multu interrupted by asynchronous reset in cycle 3
    cyc(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(3);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    cyc(MD_MFLO, 32'd0, 32'd0);
    check("t5_mf", mf_data_E, 32'd0);
    cyc(MD_MULT, 32'd6, 32'd7);
    check("t5_start", {31'd0, start}, 32'd1);
    idle(5);
    cyc(MD_NONE, 32'd0, 32'd0);
    check("t5_lo42", lo, 32'd42);

    // 6: illegal ops while busy
    cyc(MD_MULT, 32'd2, 32'd3);
    cyc(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    check("t6_start", {31'd0, start}, 32'd0);
    cyc(MD_MFHI, 32'd0, 32'd0);
    check("t6_mf", mf_data_E, 32'd0);
    check("t6_lo_keep", lo, 32'd42);
    idle(3);
    cyc(MD_NONE, 32'd0, 32'd0);
    check("t6_lo", lo, 32'd6);
    check("t6_hi", hi, 32'd0);
    check("t6_illegal_seen", n_illegal, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
